// File: rtl/instr_enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Opcodes, format and FSM state enums, and the canonical nop word.
package instr_enc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILL
  } fmt_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_e;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// Combinational packer: fields + semantic imm -> {word, fmt, err}.
// err flags immediate range violations (INSTR_ENC_IMM_CHECK_EN only).
module instr_pack
  import instr_enc_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output fmt_e        fmt,
  output logic        err
);

  logic shamt;

  // slli/srli/srai carry funct7 in the upper bits
  assign shamt = (opcode == OP_IMM) &&
                 (funct3[1:0] == 2'b01);

  always_comb begin
    fmt = FMT_ILL;
    unique case (1'b1)
      opcode == OP_R:      fmt = FMT_R;
      opcode == OP_IMM,
      opcode == OP_LOAD,
      opcode == OP_JALR:   fmt = FMT_I;
      opcode == OP_STORE:  fmt = FMT_S;
      opcode == OP_BRANCH: fmt = FMT_B;
      opcode == OP_LUI,
      opcode == OP_AUIPC:  fmt = FMT_U;
      opcode == OP_JAL:    fmt = FMT_J;
      default:             fmt = FMT_ILL;
    endcase
  end

  always_comb begin
    word = NOP;
    unique case (fmt)
      FMT_R: word = {funct7, rs2, rs1,
                     funct3, rd, opcode};
      FMT_I: begin
        if (shamt)
          word = {funct7, imm[4:0], rs1,
                  funct3, rd, opcode};
        else
          word = {imm[11:0], rs1,
                  funct3, rd, opcode};
      end
      FMT_S: word = {imm[11:5], rs2, rs1,
                     funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2,
                     rs1, funct3, imm[4:1],
                     imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1],
                     imm[11], imm[19:12],
                     rd, opcode};
      default: word = NOP;
    endcase
  end

`ifdef INSTR_ENC_IMM_CHECK_EN
  logic s12, s13, s21;

  // in range when all bits above the sign bit match it
  assign s12 = (imm[31:11] == '0) ||
               (imm[31:11] == '1);
  assign s13 = (imm[31:12] == '0) ||
               (imm[31:12] == '1);
  assign s21 = (imm[31:20] == '0) ||
               (imm[31:20] == '1);

  always_comb begin
    err = 1'b0;
    unique case (fmt)
      FMT_I,
      FMT_S:   err = !s12;
      FMT_B:   err = !s13 || imm[0];
      FMT_J:   err = !s21 || imm[0];
      FMT_U:   err = (imm[11:0] != '0);
      default: err = 1'b0;
    endcase
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/instruction_encoder.sv
// RV32I encoder and program-load streamer; bursts bounded by start/len.
// Optional macro INSTR_ENC_IMM_CHECK_EN adds immediate range errors.
module instruction_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              busy,
  output logic              done
);

  state_e           state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] accepted;
  logic [CNT_W-1:0] emitted;

  logic [31:0] pk_word;
  fmt_e        pk_fmt;
  logic        pk_err;
  logic        acc;
  logic        emit;
  logic        last;

  instr_pack u_pack (
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rs1    (rs1),
    .rs2    (rs2),
    .rd     (rd),
    .imm    (imm),
    .word   (pk_word),
    .fmt    (pk_fmt),
    .err    (pk_err)
  );

  assign in_ready = (state == S_LOAD) &&
                    (!out_valid || out_ready) &&
                    (accepted < len_q);
  assign acc  = in_valid && in_ready;
  assign emit = out_valid && out_ready;
  assign last = (emitted + CNT_W'(1)) == len_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      accepted  <= '0;
      emitted   <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      out_err   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (len != '0) begin
              state    <= S_LOAD;
              busy     <= 1'b1;
              len_q    <= len;
              accepted <= '0;
              emitted  <= '0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (acc) begin
            out_valid <= 1'b1;
            out_instr <= pk_word;
            out_err   <= pk_err ||
                         (pk_fmt == FMT_ILL);
            out_addr  <= BASE_ADDR +
                         (ADDR_W'(accepted) << 2);
            accepted  <= accepted + CNT_W'(1);
          end else if (emit) begin
            out_valid <= 1'b0;
          end
          if (emit) begin
            emitted <= emitted + CNT_W'(1);
            // final word cannot coincide with an accept
            if (last) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Sequential RISC-V RV32I instruction encoder and program-load streamer. It is the inverse of the instruction field decoder.
- Accepts instruction fields plus a semantic immediate over a valid/ready handshake. Packs them into a 32-bit instruction word in the format selected by opcode.
- Emits each word with a running instruction-memory byte address, for loading instruction memory at bring-up or from a test harness.
- A start/len sequencer bounds each load burst.

Parameters:
- ADDR_W, 32, width of out_addr.
- CNT_W, 16, width of len and the internal word counters.
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  begin a burst; sampled only in IDLE
- len  input  CNT_W  number of words in the burst; sampled with start
- in_valid  input  1  field bundle valid
- in_ready  output  1  field bundle accepted this cycle when in_valid is also high
- opcode  input  7  instruction opcode
- funct3  input  3  funct3 field
- funct7  input  7  funct7 field (R-type and shift-immediate)
- rs1  input  5  source register 1
- rs2  input  5  source register 2
- rd  input  5  destination register
- imm  input  32  semantic immediate (byte offset / value), not pre-scattered
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts the word
- out_instr  output  32  encoded instruction
- out_addr  output  ADDR_W  byte address of out_instr
- out_err  output  1  word flagged illegal
- busy  output  1  state is LOAD
- done  output  1  one-cycle pulse at burst end

Behaviour:
- Reset: state IDLE, in_ready=0, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, busy=0, done=0, counters=0.
- Reset mid-burst: any in-flight word is dropped, with no done pulse.
- FSM states are IDLE, LOAD and DONE.
- IDLE:
  - start with len!=0 -> LOAD; latch len; accepted=0, emitted=0; next address = BASE_ADDR.
  - start with len==0 -> DONE.
- LOAD: in_ready = (!out_valid || out_ready) && (accepted < len). This is combinational and gives a single-stage pipeline with no bubble.
- Input handshake (in_valid && in_ready):
  - Next cycle: out_valid=1 and out_instr=encoded word.
  - out_addr = BASE_ADDR + 4*accepted, wrapping modulo 2^ADDR_W.
  - accepted increments.
  - Latency is exactly 1 cycle.
- Output handshake (out_valid && out_ready) increments emitted.
  - out_valid clears unless a new input is accepted in the same cycle.
  - A simultaneous accept and emit is legal and does not stall.
- While out_valid=1 && out_ready=0: out_instr, out_addr and out_err are held stable.
- Burst end: the emit with emitted reaching len -> DONE. In DONE, done=1 for one cycle, then IDLE.
- start is ignored outside IDLE. in_valid is ignored in IDLE and DONE.
- Formats by opcode (bits common to all: [6:0]=opcode; rd at [11:7], funct3 at [14:12], rs1 at [19:15], rs2 at [24:20] where present):
  - R (0110011): [31:25]=funct7.
  - I (0010011, 0000011, 1100111): [31:20]=imm[11:0].
  - I, shift special case: opcode 0010011 with funct3 001 or 101 -> [31:25]=funct7, [24:20]=imm[4:0].
  - S (0100011): [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B (1100011): [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U (0110111, 0010111): [31:12]=imm[31:12].
  - J (1101111): [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - Any other opcode: out_instr=32'h0000_0013 (nop), out_err=1. The word still counts toward len.
- Immediate bits not listed above are ignored.

Optional Feature:
- Macro: INSTR_ENC_IMM_CHECK_EN.
- Defined: out_err is also set for any of the following:
  - I or S with imm not in signed 12-bit range.
  - B with imm not in signed 13-bit range, or imm[0]=1.
  - J with imm not in signed 21-bit range, or imm[0]=1.
  - U with imm[11:0]!=0.
  - The word is still encoded with truncated bits.
- Undefined: only illegal opcodes set out_err; no range logic is synthesized.

Decomposition:
- Package instr_enc_pkg:
  - Opcode constants OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL.
  - Format enum FMT_R/I/S/B/U/J/ILL.
  - State enum.
  - NOP constant.
- One sub-module, instr_pack: combinational fields+imm -> {word, fmt, err}. The top holds the FSM, counters and output register.

Test Plan:
- start len=3, then feed in order with out_ready=1:
  - addi x1,x0,5 -> 32'h00500093 @0x0
  - add x3,x1,x2 -> 32'h002081B3 @0x4
  - sw x2,8(x1) -> 32'h0020A423 @0x8
  - then done pulses once, state IDLE.
- beq x0,x0,imm=-4 -> 32'hFE000EE3. jal x1,imm=8 -> 32'h008000EF. lui x5,imm=32'h12345000 -> 32'h123452B7.
- Backpressure: out_ready=0 for 5 cycles after the first word -> out_instr/out_addr held, in_ready=0. Release -> no word lost or duplicated; addresses 0x0, 0x4 in order.
- opcode 7'b1111111 -> out_instr=32'h00000013, out_err=1, counted toward len.
- rst asserted mid-burst with out_valid=1 -> next cycle all outputs at reset values; a new start len=1 begins at BASE_ADDR. start with len=0 -> done pulse next cycle, no out_valid.
- With INSTR_ENC_IMM_CHECK_EN: addi imm=2048 -> out_err=1; beq imm=3 -> out_err=1; addi imm=-2048 -> out_err=0.
